reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 32, register and port data width.
REQ-002 Parameter ADDR_W, default 5, select width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, entry 0 hardwired to zero when 1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 EN  in  1  global enable; 0 freezes all state (entries, outputs, FSM, counter).
REQ-007 WR1, WR2  in  1 each  write enables, ports 1 and 2.
REQ-008 sel_i1, sel_i2  in  ADDR_W each  write addresses.
REQ-009 Ip1, Ip2  in  DATA_W each  write data.
REQ-010 RD  in  1  read enable for both read ports.
REQ-011 sel_o1, sel_o2  in  ADDR_W each  read addresses.
REQ-012 Op1, Op2  out  DATA_W each  registered read data.
REQ-013 clr_req  in  1  request full-array clear sweep.
REQ-014 busy  out  1  high while the clear FSM is not IDLE.
REQ-015 clr_done  out  1  one-cycle pulse on sweep completion.

Function
REQ-016 Write: at an edge with EN=1, busy=0 and WRn=1, entry[sel_in] SHALL take Ipn.
REQ-017 Write collision: WR1=WR2=1 with sel_i1=sel_i2 -> port 2 data SHALL be stored.
REQ-018 ZERO_REG=1: writes to entry 0 ignored; reads of entry 0 return 0.
REQ-019 Read: at an edge with EN=1 and RD=1, Op1/Op2 SHALL load entry[sel_o1]/entry[sel_o2]; latency 1 cycle.
REQ-020 RD=0 or EN=0: Op1/Op2 SHALL hold their previous values.
REQ-021 Bypass: read address equal to an address written at the same edge SHALL return the new data (port 2 priority per REQ-017); the zero rule of REQ-018 overrides bypass.
REQ-022 Clear FSM states: IDLE, SWEEP, DONE.
REQ-023 IDLE: clr_req=1 at an EN edge -> SWEEP, cnt=0.
REQ-024 SWEEP: each EN edge clears entry[cnt] and increments cnt; the edge with cnt=DEPTH-1 -> DONE.
REQ-025 DONE: clr_done=1 for exactly one cycle; next EN edge -> IDLE.
REQ-026 busy=1 in SWEEP and DONE, for DEPTH+1 cycles per sweep.
REQ-027 While busy=1, WR1/WR2 SHALL be ignored and clr_req SHALL be ignored.
REQ-028 Reads SHALL remain enabled while busy; an entry cleared at the same edge reads as 0.
REQ-029 EN=0 during SWEEP SHALL stall cnt and state; the sweep resumes when EN returns to 1.

Reset
REQ-030 rst=0 SHALL immediately force all entries, Op1, Op2 and cnt to 0, the FSM to IDLE, and busy and clr_done to 0, independent of clk.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep; there is no resume after release.
REQ-032 First write SHALL be honoured at the first rising edge after rst deassertion.

Structure
REQ-033 Package reg_file_pkg SHALL hold the DATA_W/ADDR_W defaults and the FSM state enumeration.
REQ-034 The clear sequencer (FSM, cnt, busy, clr_done) SHALL be sub-module reg_file_clr_fsm; array, write and read/bypass logic stay in reg_file_param.

Verification
REQ-035 Reset, then WR1, sel_i1=2, Ip1=14; next cycle RD, sel_o1=2 -> Op1=14 one cycle later; Op2 for sel_o2=6 = 0.
REQ-036 Same edge: WR1 to sel_i1=10 with Ip1=7, RD with sel_o2=10 -> Op2=7 (bypass).
REQ-037 WR1 and WR2 both to sel 5 with Ip1=0xAAAA and Ip2=0x5555 -> later read of 5 = 0x5555.
REQ-038 WR1 to sel_i1=0 with Ip1=0xFFFF_FFFF -> read of sel 0 = 0.
REQ-039 Load entries 1..31 with their index, pulse clr_req -> busy high 33 cycles, clr_done pulses once, WR1 during sweep dropped, all entries read 0 afterwards; EN=0 for 4 cycles mid-sweep extends busy to 37 cycles.
REQ-040 rst=0 mid-sweep between edges -> busy=0 and Op1=Op2=0 immediately; next clr_req restarts at cnt=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared defaults and types for the parameterised register file.
//   DATA_W_DEF / ADDR_W_DEF : default data and select widths.
//   clr_state_e             : states of the array clear sequencer.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// reg_file_clr_fsm
//   Clear sequencer: walks cnt over every entry, one entry per enabled
//   cycle, then reports completion for one state.
//   Ports:
//     clk, rst   : clock, asynchronous active-low reset
//     en         : global enable, 0 freezes state and counter
//     clr_req    : start a sweep (only sampled in IDLE)
//     busy       : high in SWEEP and DONE
//     clr_done   : high while in DONE
//     clr_en     : entry clr_addr is cleared at this edge
//     clr_addr   : entry being cleared
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= CLR_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; nothing moves while en is low
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (en) begin
      case (state_reg)
        CLR_IDLE: begin
          if (clr_req) begin
            state_next = CLR_SWEEP;
            cnt_next   = '0;
          end
        end
        CLR_SWEEP: begin
          // Counter wraps to zero as the last entry is cleared
          cnt_next = cnt_reg + ADDR_W'(1);
          if (cnt_reg == {ADDR_W{1'b1}}) begin
            state_next = CLR_DONE;
          end
        end
        CLR_DONE: begin
          state_next = CLR_IDLE;
        end
        default: begin
          state_next = CLR_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy     = (state_reg != CLR_IDLE);
    clr_done = (state_reg == CLR_DONE);
    clr_en   = en && (state_reg == CLR_SWEEP);
    clr_addr = cnt_reg;
  end

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param
//   Two-write / two-read register file with registered read data,
//   write-to-read bypass, optional hardwired zero entry and a
//   sequenced full-array clear.
//   Ports:
//     clk, rst         : clock, asynchronous active-low reset
//     EN               : global enable, 0 freezes all state
//     WR1/WR2          : write enables; port 2 wins on address collision
//     sel_i1/sel_i2    : write addresses, Ip1/Ip2 write data
//     RD               : read enable for both read ports
//     sel_o1/sel_o2    : read addresses, Op1/Op2 registered read data
//     clr_req          : start a clear sweep
//     busy, clr_done   : clear sweep status
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              WR1,
  input  logic              WR2,
  input  logic [ADDR_W-1:0] sel_i1,
  input  logic [ADDR_W-1:0] sel_i2,
  input  logic [DATA_W-1:0] Ip1,
  input  logic [DATA_W-1:0] Ip2,
  input  logic              RD,
  input  logic [ADDR_W-1:0] sel_o1,
  input  logic [ADDR_W-1:0] sel_o2,
  output logic [DATA_W-1:0] Op1,
  output logic [DATA_W-1:0] Op2,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              we1, we2;

  logic [DATA_W-1:0] entry_reg  [DEPTH];
  logic [DATA_W-1:0] entry_next [DEPTH];
  logic [DATA_W-1:0] op1_reg, op2_reg;

  reg_file_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .en       (EN),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // Writes are locked out for the whole sweep, including the DONE state
  assign we1 = EN && !busy && WR1;
  assign we2 = EN && !busy && WR2;

  // Value every entry will hold after this edge. Later assignments take
  // priority: port 2 over port 1, sweep clear over both, zero entry last.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_next[i] = entry_reg[i];
      if (we1 && (sel_i1 == ADDR_W'(i))) entry_next[i] = Ip1;
      if (we2 && (sel_i2 == ADDR_W'(i))) entry_next[i] = Ip2;
      if (clr_en && (clr_addr == ADDR_W'(i))) entry_next[i] = '0;
    end
    if (ZERO_REG != 0) begin
      entry_next[0] = '0;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry_reg[gi] <= '0;
        end else if (EN) begin
          entry_reg[gi] <= entry_next[gi];
        end
      end
    end
  endgenerate

  // Reading the post-edge view of the array gives bypass, same-edge
  // clear and the zero entry rule without extra muxing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op1_reg <= '0;
      op2_reg <= '0;
    end else if (EN && RD) begin
      op1_reg <= entry_next[sel_o1];
      op2_reg <= entry_next[sel_o2];
    end
  end

  assign Op1 = op1_reg;
  assign Op2 = op2_reg;

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN, WR1, WR2, RD, clr_req;
  logic [4:0]  sel_i1, sel_i2, sel_o1, sel_o2;
  logic [31:0] Ip1, Ip2;
  logic [31:0] Op1, Op2;
  logic        busy, clr_done;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: array contents, expected read registers, and the
  // sweep position (-1 idle, 0..31 entry to clear next, 32 done).
  logic [31:0] mdl [32];
  logic [31:0] exp_op1, exp_op2;
  int          pos;

  reg_file_param dut (
    .clk      (clk),
    .rst      (rst),
    .EN       (EN),
    .WR1      (WR1),
    .WR2      (WR2),
    .sel_i1   (sel_i1),
    .sel_i2   (sel_i2),
    .Ip1      (Ip1),
    .Ip2      (Ip2),
    .RD       (RD),
    .sel_o1   (sel_o1),
    .sel_o2   (sel_o2),
    .Op1      (Op1),
    .Op2      (Op2),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    exp_op1 = 32'h0;
    exp_op2 = 32'h0;
    pos     = -1;
  endtask

  task automatic idle_inputs();
    EN = 1'b1; WR1 = 1'b0; WR2 = 1'b0; RD = 1'b0; clr_req = 1'b0;
    sel_i1 = '0; sel_i2 = '0; sel_o1 = '0; sel_o2 = '0;
    Ip1 = '0; Ip2 = '0;
  endtask

  // One clock edge: predict from current inputs, then compare all outputs.
  task automatic tick();
    logic [31:0] nm [32];
    logic [31:0] e1, e2;
    int          np;
    bit          mbusy;
    nm = mdl;
    e1 = exp_op1;
    e2 = exp_op2;
    np = pos;
    if (EN) begin
      mbusy = (pos != -1);
      if (pos >= 0 && pos < 32) nm[pos] = 32'h0;
      if (!mbusy) begin
        if (WR1 && sel_i1 != 0) nm[sel_i1] = Ip1;
        if (WR2 && sel_i2 != 0) nm[sel_i2] = Ip2;
      end
      if (RD) begin
        e1 = nm[sel_o1];
        e2 = nm[sel_o2];
      end
      if (pos == -1) begin
        if (clr_req) np = 0;
      end else if (pos == 32) begin
        np = -1;
      end else begin
        np = pos + 1;
      end
    end
    @(posedge clk);
    #1;
    mdl     = nm;
    exp_op1 = e1;
    exp_op2 = e2;
    pos     = np;
    $display("t=%0t en=%b wr=%b%b wa=%0d/%0d rd=%b ra=%0d/%0d clr=%b op1=%h op2=%h busy=%b done=%b",
             $time, EN, WR1, WR2, sel_i1, sel_i2, RD, sel_o1, sel_o2, clr_req, Op1, Op2, busy, clr_done);
    check("op1", Op1, exp_op1);
    check("op2", Op2, exp_op2);
    check("busy", {31'h0, busy}, {31'h0, pos != -1});
    check("clr_done", {31'h0, clr_done}, {31'h0, pos == 32});
  endtask

  initial begin
    int bc, dc, guard;
    idle_inputs();
    model_reset();

    // Reset values, released between edges
    rst = 1'b0;
    #2;
    check("rst_op1", Op1, 32'h0);
    check("rst_op2", Op2, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, clr_done}, 32'h0);
    rst = 1'b1;

    // First edge after reset writes; next edge reads
    WR1 = 1'b1; sel_i1 = 5'd2; Ip1 = 32'd14;
    tick();
    idle_inputs();
    RD = 1'b1; sel_o1 = 5'd2; sel_o2 = 5'd6;
    tick();
    check("basic_op1", Op1, 32'd14);
    check("basic_op2", Op2, 32'd0);

    // Bypass on the write edge
    idle_inputs();
    WR1 = 1'b1; sel_i1 = 5'd10; Ip1 = 32'd7;
    RD = 1'b1; sel_o2 = 5'd10; sel_o1 = 5'd2;
    tick();
    check("bypass_op2", Op2, 32'd7);

    // Collision: port 2 stored, and bypass shows port 2 too
    idle_inputs();
    WR1 = 1'b1; WR2 = 1'b1; sel_i1 = 5'd5; sel_i2 = 5'd5;
    Ip1 = 32'h0000_AAAA; Ip2 = 32'h0000_5555;
    RD = 1'b1; sel_o1 = 5'd5; sel_o2 = 5'd10;
    tick();
    check("collide_bypass", Op1, 32'h0000_5555);
    idle_inputs();
    RD = 1'b1; sel_o1 = 5'd5;
    tick();
    check("collide_read", Op1, 32'h0000_5555);

    // Entry 0 stays zero, also on the bypass path
    idle_inputs();
    WR1 = 1'b1; sel_i1 = 5'd0; Ip1 = 32'hFFFF_FFFF;
    RD = 1'b1; sel_o2 = 5'd0; sel_o1 = 5'd10;
    tick();
    check("zero_bypass", Op2, 32'h0);
    idle_inputs();
    RD = 1'b1; sel_o1 = 5'd0;
    tick();
    check("zero_read", Op1, 32'h0);

    // Read hold when RD=0 and when EN=0
    idle_inputs();
    WR1 = 1'b1; sel_i1 = 5'd10; Ip1 = 32'h1111_2222;
    tick();
    check("hold_rd0", Op2, 32'd0);
    idle_inputs();
    EN = 1'b0; RD = 1'b1; sel_o1 = 5'd10;
    tick();
    check("hold_en0", Op1, 32'h0);

    // Randomized traffic, occasional sweeps and stalls
    for (int n = 0; n < 400; n++) begin
      EN      = ($urandom_range(0, 7) != 0);
      WR1     = $urandom_range(0, 1);
      WR2     = $urandom_range(0, 1);
      RD      = ($urandom_range(0, 3) != 0);
      clr_req = ($urandom_range(0, 59) == 0);
      sel_i1  = 5'($urandom_range(0, 31));
      sel_i2  = ($urandom_range(0, 3) == 0) ? sel_i1 : 5'($urandom_range(0, 31));
      sel_o1  = ($urandom_range(0, 3) == 0) ? sel_i1 : 5'($urandom_range(0, 31));
      sel_o2  = ($urandom_range(0, 3) == 0) ? sel_i2 : 5'($urandom_range(0, 31));
      Ip1     = $urandom;
      Ip2     = $urandom;
      tick();
    end

    // Let any sweep finish, then load entries with their index
    idle_inputs();
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    for (int i = 1; i < 32; i++) begin
      idle_inputs();
      WR1 = 1'b1; sel_i1 = 5'(i); Ip1 = i;
      tick();
    end

    // Full sweep; writes attempted during it must be dropped
    for (int pass = 0; pass < 2; pass++) begin
      idle_inputs();
      clr_req = 1'b1;
      tick();
      bc = 0; dc = 0; guard = 0;
      while (busy === 1'b1 && guard < 100) begin
        bc++;
        if (clr_done === 1'b1) dc++;
        idle_inputs();
        EN  = (pass == 1 && bc >= 10 && bc < 14) ? 1'b0 : 1'b1;
        WR1 = 1'b1; sel_i1 = 5'd7; Ip1 = 32'hDEAD_0007;
        clr_req = 1'b1;
        RD = 1'b1; sel_o1 = 5'($urandom_range(0, 31)); sel_o2 = 5'd7;
        tick();
        guard++;
      end
      check(pass == 0 ? "busy_cycles" : "busy_cycles_stall", bc, pass == 0 ? 33 : 37);
      check("done_pulses", dc, 1);
      for (int i = 0; i < 32; i++) begin
        idle_inputs();
        RD = 1'b1; sel_o1 = 5'(i); sel_o2 = 5'(31 - i);
        tick();
        check("cleared_op1", Op1, 32'h0);
        check("cleared_op2", Op2, 32'h0);
      end
      for (int i = 1; i < 32; i++) begin
        idle_inputs();
        WR2 = 1'b1; sel_i2 = 5'(i); Ip2 = 32'h100 + i;
        tick();
      end
    end

    // Reset mid-sweep between edges
    idle_inputs();
    RD = 1'b1; sel_o1 = 5'd3; sel_o2 = 5'd4;
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_op1", Op1, 32'h0);
    check("midrst_op2", Op2, 32'h0);
    model_reset();
    rst = 1'b1;
    for (int i = 1; i < 6; i++) begin
      idle_inputs();
      WR1 = 1'b1; sel_i1 = 5'(i); Ip1 = 32'hC0 + i;
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    RD = 1'b1; sel_o1 = 5'd1; sel_o2 = 5'd2;
    tick();
    check("restart_pre_op1", Op1, 32'hC1);
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      RD = 1'b1; sel_o1 = 5'd1; sel_o2 = 5'd3;
      tick();
    end
    check("restart_op1", Op1, 32'h0);
    check("restart_op2", Op2, 32'h0);
    idle_inputs();
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    check("restart_finish", {31'h0, busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
